mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/rr_pick.sv | 33 +++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory subsystem: RAM handshake state, data word,
// and the arbiter's FSM encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: the first asserted request strictly after ptr,
// wrapping modulo N, so the last-served slot gets the lowest priority.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          valid
);

  logic [PW-1:0] cand;

  // NOTE: every output gets a default before the search loop so that no
  // path leaves a value unassigned, which would otherwise infer latches.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for CPUS cores: dcaches beat icaches, round-robin
// inside each class, one transaction at a time through an IDLE/SERVE FSM.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [CPUS-1:0] iREN,
  input  logic [CPUS-1:0] dREN,
  input  logic [CPUS-1:0] dWEN,
  input  word_t           iaddr       [CPUS],
  input  word_t           daddr       [CPUS],
  input  word_t           dstore      [CPUS],
  output logic [CPUS-1:0] iwait,
  output logic [CPUS-1:0] dwait,
  output word_t           iload       [CPUS],
  output word_t           dload       [CPUS],
  output logic [CPUS-1:0] ccwait,
  output logic [CPUS-1:0] ccinv,
  output word_t           ccsnoopaddr [CPUS],
  input  logic [CPUS-1:0] ccwrite,
  input  logic [CPUS-1:0] cctrans,
  output logic            ramREN,
  output logic            ramWEN,
  output word_t           ramaddr,
  output word_t           ramstore,
  input  word_t           ramload,
  input  ramstate_t       ramstate
);

  localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int GW = $clog2(2 * CPUS);

  arb_state_t    state;
  logic [GW-1:0] grant;
  logic [PW-1:0] dptr, iptr;

  logic [CPUS-1:0] unused_dgnt, unused_ignt;
  logic [PW-1:0]   didx, iidx;
  logic            dvalid, ivalid;

  rr_pick #(.N(CPUS), .PW(PW)) u_dpick (
    .req(dREN | dWEN), .ptr(dptr), .gnt(unused_dgnt), .idx(didx), .valid(dvalid)
  );

  rr_pick #(.N(CPUS), .PW(PW)) u_ipick (
    .req(iREN), .ptr(iptr), .gnt(unused_ignt), .idx(iidx), .valid(ivalid)
  );

  // Grant encoding: 0..CPUS-1 are dcaches, CPUS..2*CPUS-1 are icaches.
  logic          g_icls;
  logic [PW-1:0] g_core;
  logic          req_live, serve, done;

  assign g_icls   = (grant >= GW'(CPUS));
  assign g_core   = g_icls ? PW'(grant - GW'(CPUS)) : PW'(grant);
  assign req_live = g_icls ? iREN[g_core] : (dREN[g_core] | dWEN[g_core]);
  // Reset masks the port so a transaction cut short by RST releases nothing.
  assign serve    = (state == SERVE) && req_live && !RST;
  assign done     = serve && (ramstate == ACCESS);

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    for (int k = 0; k < CPUS; k++) begin
      iload[k] = '0;
      dload[k] = '0;
    end
    if (serve) begin
      if (g_icls) begin
        ramREN        = 1'b1;
        ramaddr       = iaddr[g_core];
        iload[g_core] = ramload;
        iwait[g_core] = !done;
      end else begin
        ramWEN        = dWEN[g_core];
        ramREN        = !dWEN[g_core];
        ramaddr       = daddr[g_core];
        ramstore      = dstore[g_core];
        dload[g_core] = ramload;
        dwait[g_core] = !done;
      end
    end
  end

  assign ccwait      = '0;
  assign ccinv       = '0;
  assign ccsnoopaddr = '{default: '0};

  logic unused_cc;
  assign unused_cc = ^{ccwrite, cctrans};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      grant <= '0;
      dptr  <= PW'(CPUS - 1);
      iptr  <= PW'(CPUS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (dvalid) begin
            grant <= GW'(didx);
            state <= SERVE;
          end else if (ivalid) begin
            grant <= GW'(CPUS) + GW'(iidx);
            state <= SERVE;
          end
        end
        SERVE: begin
          if (!req_live) begin
            state <= IDLE;
          end else if (ramstate == ACCESS) begin
            state <= IDLE;
            if (g_icls) iptr <= g_core;
            else        dptr <= g_core;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (CPUS=2): reset, priority, round-robin,
// wait states, abort and mid-transaction reset.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] iREN, dREN, dWEN, iwait, dwait, ccwait, ccinv, ccwrite, cctrans;
  word_t      iaddr [2], daddr [2], dstore [2], iload [2], dload [2], ccsnoopaddr [2];
  logic       ramREN, ramWEN;
  word_t      ramaddr, ramstore, ramload;
  ramstate_t  ramstate;

  int n_checks = 0;
  int n_err    = 0;

  mem_arbiter #(.CPUS(2)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ccwrite(ccwrite), .cctrans(cctrans),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    word_t e_addr;
    RST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    iaddr = '{default: '0}; daddr = '{default: '0}; dstore = '{default: '0};
    ramload = '0; ramstate = FREE;
    tick(); tick();

    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_dwait", dwait, 2'b11);
    check("rst_iwait", iwait, 2'b11);
    check("rst_dload0", dload[0], 0);
    check("rst_ccwait", ccwait, 0);
    RST = 1'b0;

    // Both dcaches read continuously: d0, d1, d0, d1.
    dREN = 2'b11; daddr[0] = 32'h10; daddr[1] = 32'h14;
    ramstate = ACCESS; ramload = 32'h0000_5555;
    #1;
    check("rr_idle_dwait", dwait, 2'b11);
    check("rr_idle_ramREN", ramREN, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      e_addr = (k % 2 == 1) ? 32'h14 : 32'h10;
      check("rr_ramaddr", ramaddr, e_addr);
      check("rr_dwait", dwait, (k % 2 == 1) ? 2'b01 : 2'b10);
      check("rr_dload", dload[k % 2], 32'h0000_5555);
      tick();
      check("rr_gap_dwait", dwait, 2'b11);
    end
    dREN = '0;

    // d1 write with dREN also high: write wins.
    dWEN[1] = 1'b1; dREN[1] = 1'b1; daddr[1] = 32'h40; dstore[1] = 32'hDEAD_BEEF;
    #1;
    check("wr_idle_ramWEN", ramWEN, 0);
    tick();
    check("wr_ramWEN", ramWEN, 1);
    check("wr_ramREN", ramREN, 0);
    check("wr_ramaddr", ramaddr, 32'h40);
    check("wr_ramstore", ramstore, 32'hDEAD_BEEF);
    check("wr_dwait", dwait, 2'b01);
    tick();
    check("wr_after_dwait", dwait, 2'b11);
    check("wr_after_ramWEN", ramWEN, 0);
    dWEN = '0; dREN = '0; daddr[1] = 32'h14;

    // d0 aborts during BUSY; d pointer must stay on d1.
    dREN[0] = 1'b1; daddr[0] = 32'h30; ramstate = BUSY;
    tick();
    check("ab_ramREN", ramREN, 1);
    check("ab_ramaddr", ramaddr, 32'h30);
    check("ab_dwait", dwait, 2'b11);
    dREN[0] = 1'b0;
    #1;
    check("ab_drop_ramREN", ramREN, 0);
    check("ab_drop_ramaddr", ramaddr, 0);
    check("ab_drop_dwait", dwait, 2'b11);
    tick();
    check("ab_idle_ramREN", ramREN, 0);
    dREN = 2'b11; daddr[0] = 32'h10; ramstate = ACCESS;
    tick();
    check("ab_ptr_ramaddr", ramaddr, 32'h10);
    check("ab_ptr_dwait", dwait, 2'b10);
    tick();
    dREN = '0;

    // d0 and i0 together: dcache first, icache next.
    dREN[0] = 1'b1; iREN[0] = 1'b1; iaddr[0] = 32'h20; ramload = 32'hAAAA_0001;
    tick();
    check("pr_d_ramaddr", ramaddr, 32'h10);
    check("pr_d_dwait", dwait, 2'b10);
    check("pr_d_iwait", iwait, 2'b11);
    check("pr_d_dload0", dload[0], 32'hAAAA_0001);
    check("pr_d_iload0", iload[0], 0);
    tick();
    dREN[0] = 1'b0;
    tick();
    check("pr_i_ramaddr", ramaddr, 32'h20);
    check("pr_i_ramREN", ramREN, 1);
    check("pr_i_iwait", iwait, 2'b10);
    check("pr_i_iload0", iload[0], 32'hAAAA_0001);
    check("pr_i_dwait", dwait, 2'b11);
    tick();
    iREN = '0;

    // i1 read with three BUSY cycles before ACCESS.
    iREN[1] = 1'b1; iaddr[1] = 32'h100; ramstate = BUSY;
    tick();
    check("bz_ramaddr", ramaddr, 32'h100);
    check("bz_iload1", iload[1], 32'hAAAA_0001);
    for (int k = 1; k <= 3; k++) begin
      check("bz_iwait", iwait, 2'b11);
      if (k < 3) tick();
    end
    tick();
    ramstate = ACCESS; ramload = 32'h1234_5678;
    #1;
    check("bz_done_iwait", iwait, 2'b01);
    check("bz_done_iload1", iload[1], 32'h1234_5678);
    tick();
    check("bz_after_iwait", iwait, 2'b11);
    iREN = '0; ramstate = FREE;

    // Reset mid-SERVE: nothing released, pointers back to core 0.
    dREN[1] = 1'b1; ramstate = BUSY;
    tick();
    check("rs_ramaddr", ramaddr, 32'h14);
    check("rs_dwait", dwait, 2'b11);
    RST = 1'b1; ramstate = ACCESS;
    #1;
    check("rs_in_dwait", dwait, 2'b11);
    check("rs_in_ramREN", ramREN, 0);
    check("rs_in_ramaddr", ramaddr, 0);
    check("rs_in_dload1", dload[1], 0);
    tick();
    RST = 1'b0; dREN = 2'b11;
    #1;
    check("rs_idle_ramREN", ramREN, 0);
    check("rs_idle_dwait", dwait, 2'b11);
    tick();
    check("rs_next_ramaddr", ramaddr, 32'h10);
    check("rs_next_dwait", dwait, 2'b10);
    tick();
    dREN = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
